// File: rtl/uart_pkg.sv
// Shared types and constants for the UART autobaud controller.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_RESTART    = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_APPLY      = 3'd4
  } ab_state_e;

  // Falling edges of a 0x55 frame used for measurement: start bit plus four more.
  localparam int unsigned AB_FALL_EDGES = 5;
  localparam int unsigned AB_SHIFT      = 7;
  localparam int unsigned AB_ROUND      = 64;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and edge register, all reset to the idle-high level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: measures eight bit times of a received 0x55 and programs the x16 divider.
// Defining UART_AUTOBAUD_VERIFY_EN adds checking of each edge-to-edge interval against the first.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 9,
  parameter int MEAS_WIDTH = 16,
  parameter int MIN_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  ab_start,
  input  logic                  ab_abort,
  input  logic [DIV_WIDTH-1:0]  sw_div,
  input  logic                  sw_div_wr,
  output logic                  baud_en,
  output logic [DIV_WIDTH-1:0]  div_x16,
  output logic                  busy,
  output logic                  locked,
  output logic                  ab_error,
  output logic [MEAS_WIDTH-1:0] meas_cycles
);

  localparam logic [MEAS_WIDTH-1:0] CNT_ZERO  = {MEAS_WIDTH{1'b0}};
  localparam logic [MEAS_WIDTH-1:0] CNT_ONE   = MEAS_WIDTH'(1);
  localparam logic [MEAS_WIDTH-1:0] CNT_ONES  = {MEAS_WIDTH{1'b1}};
  localparam logic [MEAS_WIDTH:0]   ROUND_W   = (MEAS_WIDTH+1)'(AB_ROUND);
  localparam logic [MEAS_WIDTH:0]   MIN_W     = (MEAS_WIDTH+1)'(MIN_DIV);
  localparam logic [MEAS_WIDTH:0]   MAX_W     = (MEAS_WIDTH+1)'((1 << DIV_WIDTH) - 1);
  localparam logic [2:0]            LAST_EDGE = 3'(AB_FALL_EDGES - 2);

  ab_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  busy_q, busy_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic [MEAS_WIDTH-1:0] meas_q, meas_d;
  logic [MEAS_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]            edge_q, edge_d;
  logic                  baud_en_q;

  logic                  fall_s;
  logic [MEAS_WIDTH-1:0] cnt_inc_s;
  logic [MEAS_WIDTH:0]   result_s;
  logic                  in_range_s;
  logic                  ival_bad_s;

  uart_rx_sync u_rx_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx_in),
    .fall_o (fall_s)
  );

  assign cnt_inc_s  = cnt_q + CNT_ONE;
  // Rounded divide by 128 turns eight bit times into a x16 divider
  assign result_s   = ({1'b0, meas_q} + ROUND_W) >> AB_SHIFT;
  assign in_range_s = (result_s >= MIN_W) && (result_s <= MAX_W);

`ifdef UART_AUTOBAUD_VERIFY_EN
  logic [MEAS_WIDTH-1:0] first_q, first_d;
  logic [MEAS_WIDTH-1:0] mark_q, mark_d;
  logic [MEAS_WIDTH-1:0] ival_s;
  logic [MEAS_WIDTH-1:0] dev_s;

  // Interval since the previous falling edge and its deviation from the first interval
  always_comb begin
    ival_s = cnt_inc_s - mark_q;
    if (ival_s >= first_q) begin
      dev_s = ival_s - first_q;
    end else begin
      dev_s = first_q - ival_s;
    end
    if (edge_q != 3'd0) begin
      ival_bad_s = dev_s > (first_q >> 3'd3);
    end else begin
      ival_bad_s = 1'b0;
    end
  end

  // Next-state for the interval reference registers
  always_comb begin
    first_d = first_q;
    mark_d  = mark_q;
    if (state_q == ST_WAIT_START) begin
      first_d = CNT_ZERO;
      mark_d  = CNT_ZERO;
    end else if ((state_q == ST_MEASURE) && fall_s) begin
      mark_d = cnt_inc_s;
      if (edge_q == 3'd0) begin
        first_d = ival_s;
      end else begin
        first_d = first_q;
      end
    end else begin
      mark_d = mark_q;
    end
  end

  // Interval reference registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= CNT_ZERO;
      mark_q  <= CNT_ZERO;
    end else begin
      first_q <= first_d;
      mark_q  <= mark_d;
    end
  end
`else
  assign ival_bad_s = 1'b0;
`endif

  // FSM next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    err_d    = err_q;
    meas_d   = meas_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    case (state_q)
      ST_RESTART: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (sw_div_wr) begin
          div_d    = sw_div;
          locked_d = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_RESTART;
        end else if (ab_start) begin
          locked_d = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_WAIT_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_START: begin
        if (ab_abort) begin
          busy_d  = 1'b0;
          state_d = ST_RESTART;
        end else if (fall_s) begin
          cnt_d   = CNT_ZERO;
          edge_d  = 3'd0;
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_WAIT_START;
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_inc_s;
        if (ab_abort) begin
          busy_d  = 1'b0;
          state_d = ST_RESTART;
        end else if (cnt_q == CNT_ONES) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_RESTART;
        end else if (fall_s) begin
          if (ival_bad_s) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_RESTART;
          end else if (edge_q == LAST_EDGE) begin
            meas_d  = cnt_inc_s;
            state_d = ST_APPLY;
          end else begin
            edge_d = edge_q + 3'd1;
          end
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_APPLY: begin
        if (in_range_s) begin
          div_d    = result_s[DIV_WIDTH-1:0];
          locked_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        busy_d  = 1'b0;
        state_d = ST_RESTART;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_RESTART;
      end
    endcase
  end

  // State and output registers; baud_en follows the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESTART;
      div_q     <= {DIV_WIDTH{1'b0}};
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      meas_q    <= CNT_ZERO;
      cnt_q     <= CNT_ZERO;
      edge_q    <= 3'd0;
      baud_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      meas_q    <= meas_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      baud_en_q <= (state_d == ST_IDLE);
    end
  end

  assign baud_en     = baud_en_q;
  assign div_x16     = div_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign ab_error    = err_q;
  assign meas_cycles = meas_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Randomized self-checking bench for uart_autobaud_ctrl against a bit-time level reference model.
`timescale 1ns/1ps
module tb_uart_autobaud_ctrl;

  localparam int DIV_WIDTH  = 9;
  localparam int MEAS_WIDTH = 16;
  localparam int MIN_DIV    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  rx_in = 1'b1;
  logic                  ab_start = 1'b0;
  logic                  ab_abort = 1'b0;
  logic [DIV_WIDTH-1:0]  sw_div = '0;
  logic                  sw_div_wr = 1'b0;
  logic                  baud_en;
  logic [DIV_WIDTH-1:0]  div_x16;
  logic                  busy;
  logic                  locked;
  logic                  ab_error;
  logic [MEAS_WIDTH-1:0] meas_cycles;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_div = 0;
  int unsigned exp_meas = 0;
  bit          exp_locked = 1'b0;
  bit          exp_err = 1'b0;
  bit          drv_done = 1'b0;

  always #10 clk = ~clk;

  uart_autobaud_ctrl #(
    .DIV_WIDTH  (DIV_WIDTH),
    .MEAS_WIDTH (MEAS_WIDTH),
    .MIN_DIV    (MIN_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .ab_start    (ab_start),
    .ab_abort    (ab_abort),
    .sw_div      (sw_div),
    .sw_div_wr   (sw_div_wr),
    .baud_en     (baud_en),
    .div_x16     (div_x16),
    .busy        (busy),
    .locked      (locked),
    .ab_error    (ab_error),
    .meas_cycles (meas_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: eight bit times rounded to a x16 divider, accepted only inside the legal range.
  task automatic model_measure(input int unsigned iv[4]);
    int unsigned total;
    int unsigned r;
    bit          bad;
    total = iv[0] + iv[1] + iv[2] + iv[3];
    bad   = 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
    for (int k = 1; k < 4; k++) begin
      int unsigned d;
      d = (iv[k] > iv[0]) ? iv[k] - iv[0] : iv[0] - iv[k];
      if (d > iv[0] / 8) bad = 1'b1;
    end
`endif
    if (bad) begin
      exp_err = 1'b1;
    end else begin
      exp_meas = total;
      r = (total + 64) / 128;
      if (r >= MIN_DIV && r < (1 << DIV_WIDTH)) begin
        exp_div    = r;
        exp_locked = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".div"}, 32'(div_x16), exp_div);
    check_eq({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    check_eq({tag, ".err"}, 32'(ab_error), 32'(exp_err));
    check_eq({tag, ".meas"}, 32'(meas_cycles), exp_meas);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic start_meas(input string tag);
    ab_start = 1'b1;
    tick(1);
    ab_start = 1'b0;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    check_eq({tag, ".busy_set"}, 32'(busy), 32'd1);
    check_eq({tag, ".baud_off"}, 32'(baud_en), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick(1);
      n++;
    end
    check_eq({tag, ".done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_gap(input string tag);
    check_eq({tag, ".gap0"}, 32'(baud_en), 32'd0);
    tick(1);
    check_eq({tag, ".gap1"}, 32'(baud_en), 32'd1);
  endtask

  task automatic drive_frame(input int p, input int stretch);
    logic [9:0] frame;
    frame = 10'b1010101010;
    for (int i = 0; i < 10; i++) begin
      rx_in = frame[i];
      repeat (p + ((i == 5) ? stretch : 0)) @(posedge clk);
      #1;
    end
    drv_done = 1'b1;
  endtask

  task automatic autobaud(input string tag, input int p, input int stretch, input bit gap_chk);
    int unsigned iv[4];
    int          n;
    start_meas(tag);
    sw_div    = DIV_WIDTH'($urandom);
    sw_div_wr = 1'b1;
    ab_start  = 1'b1;
    tick(1);
    sw_div_wr = 1'b0;
    ab_start  = 1'b0;
    check_eq({tag, ".busy_ign"}, 32'(busy), 32'd1);
    tick(1);
    drv_done = 1'b0;
    fork
      drive_frame(p, stretch);
    join_none
    wait_idle(tag, 12 * p + 80);
    if (gap_chk) check_gap(tag);
    n = 0;
    while (!drv_done && n < 4 * p + 200) begin
      tick(1);
      n++;
    end
    check_eq({tag, ".drv"}, 32'(drv_done), 32'd1);
    tick(4);
    iv[0] = 2 * p;
    iv[1] = 2 * p;
    iv[2] = 2 * p + stretch;
    iv[3] = 2 * p;
    model_measure(iv);
    check_state(tag);
  endtask

  initial begin
    #5;
    check_eq("rst.baud", 32'(baud_en), 32'd0);
    check_state("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst.restart", 32'(baud_en), 32'd0);
    tick(1);
    check_eq("rst.idle", 32'(baud_en), 32'd1);

    sw_div    = DIV_WIDTH'($urandom_range(511, 1));
    sw_div_wr = 1'b1;
    tick(1);
    sw_div_wr = 1'b0;
    exp_div   = 32'(sw_div);
    check_gap("swwr");
    check_state("swwr");

    autobaud("p434", 434, 0, 1'b1);
    check_eq("p434.meas", 32'(meas_cycles), 32'd3472);
    check_eq("p434.div", 32'(div_x16), 32'd27);
    autobaud("p23", 23, 0, 1'b1);
    autobaud("p24", 24, 0, 1'b1);
    for (int t = 0; t < 5; t++) begin
      autobaud("rnd", $urandom_range(120, 16), 0, 1'b1);
    end

    start_meas("tmo");
    tick(2);
    rx_in = 1'b0;
    wait_idle("tmo", 70000);
    check_gap("tmo");
    exp_err = 1'b1;
    check_state("tmo");
    rx_in = 1'b1;
    tick(5);

    sw_div    = DIV_WIDTH'(100);
    sw_div_wr = 1'b1;
    ab_start  = 1'b1;
    tick(1);
    sw_div_wr = 1'b0;
    ab_start  = 1'b0;
    exp_div    = 100;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    check_eq("both.busy", 32'(busy), 32'd0);
    check_gap("both");
    check_state("both");

    start_meas("abort");
    tick(2);
    rx_in = 1'b0;
    tick(30);
    ab_abort = 1'b1;
    tick(1);
    ab_abort = 1'b0;
    check_gap("abort");
    check_state("abort");
    rx_in = 1'b1;
    tick(5);

    start_meas("reset");
    tick(2);
    rx_in = 1'b0;
    tick(40);
    #3;
    rst_n = 1'b0;
    #2;
    exp_div  = 0;
    exp_meas = 0;
    exp_locked = 1'b0;
    exp_err  = 1'b0;
    check_eq("reset.baud", 32'(baud_en), 32'd0);
    check_state("reset");
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("reset.restart", 32'(baud_en), 32'd0);
    tick(1);
    check_eq("reset.idle", 32'(baud_en), 32'd1);
    check_state("reset.after");

`ifdef UART_AUTOBAUD_VERIFY_EN
    autobaud("vfy_ok", 200, 0, 1'b1);
    autobaud("vfy_bad", 200, 80, 1'b0);
    check_eq("vfy_bad.err", 32'(ab_error), 32'd1);
    check_eq("vfy_bad.locked", 32'(locked), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_ctrl.md
UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 9: width of the divider driven to the x16 baud generator.
REQ-002 Parameter MEAS_WIDTH, default 16: measurement counter width, SHALL be at least DIV_WIDTH+7.
REQ-003 Parameter MIN_DIV, default 2: smallest measured divider accepted.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rx_in  in  1  asynchronous serial line, idle high.
REQ-007 ab_start  in  1  one-cycle pulse that starts autobaud measurement.
REQ-008 ab_abort  in  1  one-cycle pulse that cancels a measurement.
REQ-009 sw_div  in  DIV_WIDTH  software divider value.
REQ-010 sw_div_wr  in  1  one-cycle pulse that loads sw_div.
REQ-011 baud_en  out  1  enable to the baud generator.
REQ-012 div_x16  out  DIV_WIDTH  divider to the baud generator; 0 selects the generator default.
REQ-013 busy  out  1  high while measuring.
REQ-014 locked  out  1  high after a successful autobaud.
REQ-015 ab_error  out  1  sticky autobaud failure flag.
REQ-016 meas_cycles  out  MEAS_WIDTH  last captured 8-bit-time count.

Function
REQ-017 FSM states SHALL be RESTART, IDLE, WAIT_START, MEASURE, APPLY.
- RESTART: baud_en=0 for exactly one cycle, then IDLE.
- IDLE: baud_en=1.
REQ-018 rx_in SHALL pass a 2-flop synchronizer plus an edge register; a falling edge is seen 3 cycles after the pin falls.
REQ-019 In IDLE, sw_div_wr SHALL load div_x16<=sw_div, clear locked and ab_error, and go to RESTART; this realigns the generator phase.
REQ-020 In IDLE, ab_start without sw_div_wr SHALL clear locked and ab_error, set busy, drive baud_en=0, and go to WAIT_START.
REQ-021 If sw_div_wr and ab_start arrive in the same IDLE cycle, sw_div_wr SHALL win and ab_start SHALL be ignored.
REQ-022 While busy, sw_div_wr and ab_start SHALL be ignored.
REQ-023 WAIT_START: on the first falling edge, clear the counter and go to MEASURE.
REQ-024 MEASURE: the counter SHALL increment every cycle.
- On the 4th subsequent falling edge (the start of stop-side bit 8 of 0x55), capture meas_cycles = counter+1 (8 bit times) and go to APPLY.
REQ-025 APPLY: result = (meas_cycles+64)>>7, computed at MEAS_WIDTH+1 bits.
- If MIN_DIV <= result <= 2^DIV_WIDTH-1: div_x16<=result, locked<=1.
- Otherwise: ab_error<=1 and div_x16 is unchanged.
- Either way, clear busy and go to RESTART.
REQ-026 If the counter reaches all-ones in MEASURE (timeout), set ab_error, leave div_x16 unchanged, and go to RESTART.
REQ-027 ab_abort in WAIT_START or MEASURE SHALL clear busy, leave div_x16 and the flags unchanged, and go to RESTART; in other states it SHALL be ignored.
REQ-028 baud_en SHALL be 0 in every state except IDLE.

Reset
REQ-029 Async reset SHALL set:
- state=RESTART
- baud_en=0, div_x16=0, busy=0, locked=0, ab_error=0, meas_cycles=0
- synchronizer flops=1
REQ-030 Reset during a measurement SHALL discard it; the first post-reset cycle is RESTART and the second is IDLE with baud_en=1.

Configuration
REQ-031 With macro UART_AUTOBAUD_VERIFY_EN defined:
- Each of the 4 falling-edge-to-falling-edge intervals is checked against the first interval.
- A deviation greater than first>>3 sets ab_error and goes to RESTART without applying.
REQ-032 Without UART_AUTOBAUD_VERIFY_EN, no interval checking is done and the interval registers are absent.

Structure
REQ-033 Package uart_pkg SHALL hold:
- the FSM state enum
- AB_FALL_EDGES=5
- AB_SHIFT=7
- AB_ROUND=64
REQ-034 Sub-module uart_rx_sync SHALL contain the synchronizer and the falling-edge detect.

Verification
REQ-035 50 MHz clock, rx sends 0x55 at 5208 cycles/bit after ab_start -> locked=1, div_x16=326, baud_en 0 for one cycle then 1.
REQ-036 0x55 at 434 cycles/bit -> meas_cycles=3472, div_x16=27, locked=1.
REQ-037 ab_start, one falling edge, then rx held low -> ab_error=1 after 65535 measurement cycles, div_x16 unchanged, baud_en returns to 1.
REQ-038 sw_div_wr=100 and ab_start in the same IDLE cycle -> div_x16=100, busy stays 0, one-cycle baud_en=0 gap.
REQ-039 ab_abort mid-MEASURE, then reset asserted mid-measurement -> busy=0, div_x16 retained after the abort and 0 after the reset, baud_en=1 on the 2nd post-reset cycle.
REQ-040 With UART_AUTOBAUD_VERIFY_EN, 0x55 with one 2-bit interval stretched by 20% -> ab_error=1, locked=0.
